// File: rtl/snake_step_sched_pkg.sv
// Shared types, direction/state codes and turn-filter helpers for the snake step scheduler.
package snake_step_sched_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t TOP_DIR   = 2'b00;
  localparam dir_t RIGHT_DIR = 2'b01;
  localparam dir_t DOWN_DIR  = 2'b10;
  localparam dir_t LEFT_DIR  = 2'b11;
  localparam dir_t REV_MASK  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  function automatic dir_t reverse_dir(input dir_t d);
    return d ^ REV_MASK;
  endfunction

  // A turn is useful only if it neither repeats nor reverses the reference heading.
  function automatic logic turn_ok(input dir_t req, input dir_t ref_dir);
    return (req != ref_dir) && (req != reverse_dir(ref_dir));
  endfunction

endpackage

// File: rtl/snake_step_sched_if.sv
// Step handshake between the scheduler (master) and the movement datapath (slave).
interface snake_step_sched_if;
  import snake_step_sched_pkg::*;

  logic step_req;
  dir_t step_dir;
  logic step_ack;
  logic collision;
  logic grow;

  modport master (
    output step_req,
    output step_dir,
    input  step_ack,
    input  collision,
    input  grow
  );

  modport slave (
    input  step_req,
    input  step_dir,
    output step_ack,
    output collision,
    output grow
  );

endinterface

// File: rtl/snake_step_sched_dir_queue.sv
// Small turn FIFO (head at index 0) with duplicate/reversal filtering against the newest heading.
module dir_queue
  import snake_step_sched_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic sys_clk,
  input  logic clr,
  input  logic push_req,
  input  dir_t push_dir,
  input  logic pop,
  input  dir_t cur_dir,
  output dir_t head,
  output logic empty,
  output logic full,
  output logic push_ok
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  dir_t          q_r [QDEPTH];
  logic [CW-1:0] cnt_r;

  logic [CW-1:0] tail_cnt_s;
  logic [IW-1:0] tail_idx_s;
  logic [IW-1:0] wr_idx_s;
  dir_t          ref_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;

  // Reference heading, accept decision and write slot; a full queue still accepts when popping.
  always_comb begin
    empty_s    = (cnt_r == {CW{1'b0}});
    full_s     = (cnt_r == CW'(QDEPTH));
    tail_cnt_s = cnt_r - CW'(1);
    tail_idx_s = tail_cnt_s[IW-1:0];
    ref_s      = empty_s ? cur_dir : q_r[tail_idx_s];
    pop_s      = pop && !empty_s;
    push_s     = push_req && turn_ok(push_dir, ref_s) && (!full_s || pop_s);
    wr_idx_s   = pop_s ? tail_idx_s : cnt_r[IW-1:0];
  end

  // Shift-down storage and occupancy count.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      cnt_r <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_r[i] <= TOP_DIR;
      end
    end else begin
      if (pop_s) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          q_r[i] <= q_r[i+1];
        end
      end
      if (push_s) begin
        q_r[wr_idx_s] <= push_dir;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head    = q_r[0];
  assign empty   = empty_s;
  assign full    = full_s;
  assign push_ok = push_s;

endmodule

// File: rtl/snake_step_sched.sv
// Game-step scheduler: turn queue, move tick, step handshake and IDLE/RUN/PAUSE/OVER FSM.
// Optional speed-up on grow is enabled by defining SNAKE_SPEEDUP_EN.
module snake_step_sched
  import snake_step_sched_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int TICK_MIN    = 1_250_000,
  parameter int TICK_STEP   = 250_000,
  parameter int QDEPTH      = 2,
  parameter int CNT_W       = 23
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                dir_valid,
  input  dir_t                dir_in,
  input  logic                start,
  input  logic                pause,
  snake_step_sched_if.master  step_bus,
  output logic [1:0]          state,
  output logic [3:0]          speed_lvl
);

`ifdef SNAKE_SPEEDUP_EN
  localparam logic SPEEDUP_EN = 1'b1;
`else
  localparam logic SPEEDUP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(TICK_MIN);
  localparam logic [CNT_W:0]   PERIOD_DEC = (CNT_W + 1)'(TICK_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             step_req_r;
  dir_t             step_dir_r;
  dir_t             cur_dir_r;
  logic [3:0]       speed_lvl_r;

  logic             active_s;
  logic             init_s;
  logic             ack_s;
  logic             cnt_en_s;
  logic             tick_s;
  logic             q_clr_s;
  logic             q_push_req_s;
  logic             q_empty_s;
  logic             q_full_s;
  logic             q_push_ok_s;
  dir_t             q_head_s;
  logic [CNT_W:0]   period_sub_s;
  logic [CNT_W-1:0] period_next_s;

  dir_queue #(
    .QDEPTH (QDEPTH)
  ) u_dir_queue (
    .sys_clk  (sys_clk),
    .clr      (q_clr_s),
    .push_req (q_push_req_s),
    .push_dir (dir_in),
    .pop      (tick_s),
    .cur_dir  (cur_dir_r),
    .head     (q_head_s),
    .empty    (q_empty_s),
    .full     (q_full_s),
    .push_ok  (q_push_ok_s)
  );

  // Qualifiers; a pause pulse freezes the count on the very edge it is sampled.
  always_comb begin
    active_s     = (state_r == ST_RUN) || (state_r == ST_PAUSE);
    init_s       = !active_s && start;
    ack_s        = active_s && step_req_r && step_bus.step_ack;
    cnt_en_s     = (state_r == ST_RUN) && !pause && !step_req_r;
    tick_s       = cnt_en_s && (tick_cnt_r == (period_r - CNT_ONE));
    q_clr_s      = sys_rst || init_s;
    q_push_req_s = active_s && dir_valid;
    period_sub_s = {1'b0, period_r} - PERIOD_DEC;
    if (period_sub_s[CNT_W] || (period_sub_s < {1'b0, PERIOD_MIN})) begin
      period_next_s = PERIOD_MIN;
    end else begin
      period_next_s = period_sub_s[CNT_W-1:0];
    end
  end

  // Game FSM next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (ack_s && step_bus.collision) begin
          state_nxt_s = ST_OVER;
        end else if (pause) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ack_s && step_bus.collision) begin
          state_nxt_s = ST_OVER;
        end else if (pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Game FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Tick counter, step request/direction and speed-up state; start from IDLE/OVER reinitialises.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || init_s) begin
      tick_cnt_r  <= {CNT_W{1'b0}};
      period_r    <= PERIOD_RST;
      step_req_r  <= 1'b0;
      step_dir_r  <= TOP_DIR;
      cur_dir_r   <= TOP_DIR;
      speed_lvl_r <= 4'd0;
    end else begin
      if (tick_s) begin
        tick_cnt_r <= {CNT_W{1'b0}};
        step_req_r <= 1'b1;
        if (!q_empty_s) begin
          cur_dir_r  <= q_head_s;
          step_dir_r <= q_head_s;
        end else begin
          step_dir_r <= cur_dir_r;
        end
      end else if (cnt_en_s) begin
        tick_cnt_r <= tick_cnt_r + CNT_ONE;
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
      if (ack_s) begin
        step_req_r <= 1'b0;
        if (SPEEDUP_EN && step_bus.grow) begin
          period_r <= period_next_s;
          if (speed_lvl_r != 4'hF) begin
            speed_lvl_r <= speed_lvl_r + 4'd1;
          end
        end
      end
    end
  end

  assign step_bus.step_req = step_req_r;
  assign step_bus.step_dir = step_dir_r;
  assign state             = state_r;
  assign speed_lvl         = speed_lvl_r;

endmodule

// File: tb/tb_snake_step_sched.sv
// Directed self-checking bench for snake_step_sched (TICK_CYCLES=8, TICK_MIN=4, TICK_STEP=2, QDEPTH=2).
module tb_snake_step_sched;
  import snake_step_sched_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       dir_valid;
  dir_t       dir_in;
  logic       start;
  logic       pause;
  logic [1:0] state;
  logic [3:0] speed_lvl;

  int n_vec = 0;
  int n_err = 0;

  snake_step_sched_if bus ();

  snake_step_sched #(
    .TICK_CYCLES (8),
    .TICK_MIN    (4),
    .TICK_STEP   (2),
    .QDEPTH      (2),
    .CNT_W       (23)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .dir_valid (dir_valid),
    .dir_in    (dir_in),
    .start     (start),
    .pause     (pause),
    .step_bus  (bus),
    .state     (state),
    .speed_lvl (speed_lvl)
  );

  always #5 sys_clk = ~sys_clk;

`ifdef SNAKE_SPEEDUP_EN
  int exp_per [3] = '{6, 4, 4};
  int exp_lvl [3] = '{1, 2, 3};
`else
  int exp_per [3] = '{8, 8, 8};
  int exp_lvl [3] = '{0, 0, 0};
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (bus.step_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_ack(input logic col, input logic grw);
    bus.step_ack  = 1'b1;
    bus.collision = col;
    bus.grow      = grw;
    tick();
    bus.step_ack  = 1'b0;
    bus.collision = 1'b0;
    bus.grow      = 1'b0;
  endtask

  task automatic push_dir(input dir_t d);
    dir_valid = 1'b1;
    dir_in    = d;
    tick();
    dir_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    tick();
    pause = 1'b0;
  endtask

  initial begin
    int n;
    sys_rst       = 1'b1;
    dir_valid     = 1'b0;
    dir_in        = TOP_DIR;
    start         = 1'b0;
    pause         = 1'b0;
    bus.step_ack  = 1'b0;
    bus.collision = 1'b0;
    bus.grow      = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    check_val("rst_state", 32'(state), 32'(ST_IDLE));
    check_val("rst_req", 32'(bus.step_req), 32'd0);
    check_val("rst_dir", 32'(bus.step_dir), 32'(TOP_DIR));
    check_val("rst_lvl", 32'(speed_lvl), 32'd0);

    // 1: basic tick latency and handshake
    pulse_start();
    check_val("t1_state", 32'(state), 32'(ST_RUN));
    wait_req(20, n);
    check_val("t1_lat0", 32'(n), 32'd8);
    check_val("t1_dir0", 32'(bus.step_dir), 32'(TOP_DIR));
    tick();
    check_val("t1_hold", 32'(bus.step_req), 32'd1);
    do_ack(1'b0, 1'b0);
    check_val("t1_drop", 32'(bus.step_req), 32'd0);
    wait_req(20, n);
    check_val("t1_lat1", 32'(n), 32'd8);
    check_val("t1_dir1", 32'(bus.step_dir), 32'(TOP_DIR));
    do_ack(1'b0, 1'b0);

    // stray ack with collision while no request is outstanding
    do_ack(1'b1, 1'b0);
    check_val("stray_ack", 32'(state), 32'(ST_RUN));

    // 2: queue RIGHT, DOWN; LEFT dropped as full
    push_dir(RIGHT_DIR);
    push_dir(DOWN_DIR);
    push_dir(LEFT_DIR);
    wait_req(20, n);
    check_val("t2_lat", 32'(n), 32'd4);
    check_val("t2_dir0", 32'(bus.step_dir), 32'(RIGHT_DIR));
    do_ack(1'b0, 1'b0);
    wait_req(20, n);
    check_val("t2_dir1", 32'(bus.step_dir), 32'(DOWN_DIR));
    do_ack(1'b0, 1'b0);
    wait_req(20, n);
    check_val("t2_dir2", 32'(bus.step_dir), 32'(DOWN_DIR));

    // 3: cur=DOWN; TOP reversal and DOWN duplicate rejected; LEFT reverses queued RIGHT
    push_dir(TOP_DIR);
    push_dir(DOWN_DIR);
    push_dir(RIGHT_DIR);
    push_dir(LEFT_DIR);
    do_ack(1'b0, 1'b0);
    wait_req(20, n);
    check_val("t3_dir0", 32'(bus.step_dir), 32'(RIGHT_DIR));
    do_ack(1'b0, 1'b0);
    wait_req(20, n);
    check_val("t3_dir1", 32'(bus.step_dir), 32'(RIGHT_DIR));

    // 4: speed-up on grow
    for (int i = 0; i < 3; i++) begin
      do_ack(1'b0, 1'b1);
      check_val("t4_lvl", 32'(speed_lvl), 32'(exp_lvl[i]));
      wait_req(20, n);
      check_val("t4_per", 32'(n), 32'(exp_per[i]));
    end

    // 6a: collision -> OVER; queued turn must not survive restart
    push_dir(DOWN_DIR);
    do_ack(1'b1, 1'b0);
    check_val("t6_over", 32'(state), 32'(ST_OVER));
    check_val("t6_req", 32'(bus.step_req), 32'd0);
    pulse_pause();
    check_val("t6_over_pause", 32'(state), 32'(ST_OVER));
    pulse_start();
    check_val("t6_restart", 32'(state), 32'(ST_RUN));
    check_val("t6_lvl", 32'(speed_lvl), 32'd0);
    tick();
    tick();
    pulse_start();
    wait_req(20, n);
    check_val("t6_lat", 32'(n + 3), 32'd8);
    check_val("t6_dir", 32'(bus.step_dir), 32'(TOP_DIR));
    do_ack(1'b0, 1'b0);

    // 5: pause with tick_cnt=3, hold 20 cycles, resume
    repeat (3) tick();
    pulse_pause();
    check_val("t5_pause", 32'(state), 32'(ST_PAUSE));
    repeat (20) tick();
    check_val("t5_frozen", 32'(bus.step_req), 32'd0);
    pulse_pause();
    check_val("t5_resume", 32'(state), 32'(ST_RUN));
    wait_req(20, n);
    check_val("t5_lat", 32'(n), 32'd5);

    // pause with an outstanding request, then collision while paused
    pulse_pause();
    check_val("t5p_state", 32'(state), 32'(ST_PAUSE));
    repeat (3) tick();
    check_val("t5p_req", 32'(bus.step_req), 32'd1);
    do_ack(1'b1, 1'b0);
    check_val("t5p_over", 32'(state), 32'(ST_OVER));
    check_val("t5p_drop", 32'(bus.step_req), 32'd0);

    // 6b: reset while a request is outstanding
    pulse_start();
    wait_req(20, n);
    check_val("t6b_req", 32'(bus.step_req), 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_val("t6b_rst_req", 32'(bus.step_req), 32'd0);
    check_val("t6b_rst_state", 32'(state), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
